// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file slice.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default datapath width and register count
//   ZERO_ADDR                     : address of the hard-wired zero register
//   clog2()                       : elaboration-time address-width helper
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 32;
  localparam int ZERO_ADDR     = 0;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set when a long-latency op
// is issued and cleared when its port B writeback lands.
//   clk, reset          : clock, async active-high reset
//   ra1, ra2            : read addresses whose pending state is reported
//   we_b, wa_b          : long-latency writeback (clears the pending bit)
//   issue_valid/dst     : request to mark a destination pending
//   issue_ok            : issue accepted this cycle
//   busy1, busy2        : pending state of ra1 / ra2
//   sb_err              : sticky, port B wrote a register that was not pending
module regfile_sb_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  input  logic          we_b,
  input  logic [AW-1:0] wa_b,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_dst,
  output logic          issue_ok,
  output logic          busy1,
  output logic          busy2,
  output logic          sb_err
);

  logic [DEPTH-1:0] sb;
  logic [DEPTH-1:0] sb_next;
  logic             b_live;
  logic             dst_busy;
  logic             stray_b;

  // Writes to the zero register are dropped entirely, so they neither clear
  // the scoreboard nor count as a stray writeback.
  assign b_live   = we_b && !(ZERO_REG != 0 && wa_b == AW'(ZERO_ADDR));
  assign stray_b  = b_live && !sb[wa_b];

  // A destination whose writeback lands this cycle is free for a new issue.
  assign dst_busy = sb[issue_dst] && !(b_live && wa_b == issue_dst);
  assign issue_ok = issue_valid && !dst_busy &&
                    !(ZERO_REG != 0 && issue_dst == AW'(ZERO_ADDR));

  // Clear first, then set: a same-cycle issue to the same register wins.
  always_comb begin
    sb_next = sb;
    if (b_live)
      sb_next[wa_b] = 1'b0;
    if (issue_ok)
      sb_next[issue_dst] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb     <= '0;
      sb_err <= 1'b0;
    end else begin
      sb <= sb_next;
      if (stray_b)
        sb_err <= 1'b1;
    end
  end

  always_comb begin
    busy1 = sb[ra1];
    if (BYPASS != 0 && we_b && wa_b == ra1)
      busy1 = 1'b0;
    if (ZERO_REG != 0 && ra1 == AW'(ZERO_ADDR))
      busy1 = 1'b0;
  end

  always_comb begin
    busy2 = sb[ra2];
    if (BYPASS != 0 && we_b && wa_b == ra2)
      busy2 = 1'b0;
    if (ZERO_REG != 0 && ra2 == AW'(ZERO_ADDR))
      busy2 = 1'b0;
  end

endmodule

// File: rtl/regfile_sb.sv
// Two-read / two-write register file with a pending-write scoreboard.
//   clk, reset            : clock, async active-high reset
//   ra1/ra2, rd1/rd2      : asynchronous read ports (optionally bypassed)
//   busy1/busy2           : pending state of the read addresses
//   we_a/wa_a/wd_a        : single-cycle ALU write port
//   we_b/wa_b/wd_b        : long-latency writeback port (wins collisions)
//   issue_valid/issue_dst : mark a long-latency destination pending
//   issue_ok              : issue accepted this cycle
//   collide               : one-cycle pulse after a dropped port A write
//   sb_err                : sticky stray-writeback flag
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             busy1,
  output logic             busy2,
  input  logic             we_a,
  input  logic [AW-1:0]    wa_a,
  input  logic [WIDTH-1:0] wd_a,
  input  logic             we_b,
  input  logic [AW-1:0]    wa_b,
  input  logic [WIDTH-1:0] wd_b,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_dst,
  output logic             issue_ok,
  output logic             collide,
  output logic             sb_err
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             live_a;
  logic             live_b;
  logic             collision;
  logic             wr_a;

  assign live_a    = we_a && !(ZERO_REG != 0 && wa_a == AW'(ZERO_ADDR));
  assign live_b    = we_b && !(ZERO_REG != 0 && wa_b == AW'(ZERO_ADDR));
  assign collision = live_a && live_b && wa_a == wa_b;
  assign wr_a      = live_a && !collision;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      collide <= 1'b0;
    end else begin
      if (wr_a)
        mem[wa_a] <= wd_a;
      if (live_b)
        mem[wa_b] <= wd_b;
      collide <= collision;
    end
  end

  // Port B has priority in the bypass so forwarded data matches what the
  // array will hold after a collision.
  always_comb begin
    rd1 = mem[ra1];
    if (BYPASS != 0 && we_a && wa_a == ra1)
      rd1 = wd_a;
    if (BYPASS != 0 && we_b && wa_b == ra1)
      rd1 = wd_b;
    if (ZERO_REG != 0 && ra1 == AW'(ZERO_ADDR))
      rd1 = '0;
  end

  always_comb begin
    rd2 = mem[ra2];
    if (BYPASS != 0 && we_a && wa_a == ra2)
      rd2 = wd_a;
    if (BYPASS != 0 && we_b && wa_b == ra2)
      rd2 = wd_b;
    if (ZERO_REG != 0 && ra2 == AW'(ZERO_ADDR))
      rd2 = '0;
  end

  regfile_sb_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_sb (
    .clk         (clk),
    .reset       (reset),
    .ra1         (ra1),
    .ra2         (ra2),
    .we_b        (we_b),
    .wa_b        (wa_b),
    .issue_valid (issue_valid),
    .issue_dst   (issue_dst),
    .issue_ok    (issue_ok),
    .busy1       (busy1),
    .busy2       (busy2),
    .sb_err      (sb_err)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a bypassing instance and a non-bypassing
// instance share all inputs; expected values are hand-computed.
module tb_regfile_sb;

  logic        clk;
  logic        reset;
  logic [4:0]  ra1, ra2, wa_a, wa_b, issue_dst;
  logic [31:0] wd_a, wd_b;
  logic        we_a, we_b, issue_valid;

  logic [31:0] rd1, rd2, rd1_nb, rd2_nb;
  logic        busy1, busy2, issue_ok, collide, sb_err;
  logic        busy1_nb, busy2_nb, issue_ok_nb, collide_nb, sb_err_nb;

  int vectors;
  int miscompares;

  regfile_sb dut (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2), .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b), .issue_valid(issue_valid),
    .issue_dst(issue_dst), .issue_ok(issue_ok), .collide(collide), .sb_err(sb_err)
  );

  regfile_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_nb), .rd2(rd2_nb),
    .busy1(busy1_nb), .busy2(busy2_nb), .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b), .issue_valid(issue_valid),
    .issue_dst(issue_dst), .issue_ok(issue_ok_nb), .collide(collide_nb),
    .sb_err(sb_err_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_a = 1'b0; we_b = 1'b0; issue_valid = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    ra1 = '0; ra2 = '0; wa_a = '0; wa_b = '0; issue_dst = '0;
    wd_a = '0; wd_b = '0;
    idle();
    #3;
    check("reset_rd1", rd1, 32'h0);
    check("reset_busy1", {31'b0, busy1}, 32'h0);
    check("reset_collide", {31'b0, collide}, 32'h0);
    check("reset_sb_err", {31'b0, sb_err}, 32'h0);
    tick();
    tick();
    reset = 1'b0;

    // Basic write/read and zero register
    we_a = 1'b1; wa_a = 5'd5; wd_a = 32'h1234_5678;
    tick();
    idle();
    ra1 = 5'd5; ra2 = 5'd0;
    #1;
    check("r5_read", rd1, 32'h1234_5678);
    check("r0_read", rd2, 32'h0);
    we_a = 1'b1; wa_a = 5'd0; wd_a = 32'hFFFF_FFFF;
    #1;
    check("r0_bypass_blocked", rd2, 32'h0);
    tick();
    idle();
    #1;
    check("r0_after_write", rd2, 32'h0);
    check("r0_no_collide", {31'b0, collide}, 32'h0);

    // Bypass vs. no bypass
    we_a = 1'b1; wa_a = 5'd7; wd_a = 32'hA5A5_A5A5; ra1 = 5'd7;
    #1;
    check("bypass_rd1", rd1, 32'hA5A5_A5A5);
    check("nobypass_old", rd1_nb, 32'h0);
    tick();
    idle();
    #1;
    check("nobypass_new", rd1_nb, 32'hA5A5_A5A5);

    // Scoreboard flow on r9
    issue_valid = 1'b1; issue_dst = 5'd9;
    #1;
    check("issue9_ok", {31'b0, issue_ok}, 32'h1);
    tick();
    idle();
    ra1 = 5'd9;
    #1;
    check("r9_busy", {31'b0, busy1}, 32'h1);
    issue_valid = 1'b1; issue_dst = 5'd9;
    #1;
    check("issue9_waw", {31'b0, issue_ok}, 32'h0);
    tick();
    idle();
    #1;
    check("r9_still_busy", {31'b0, busy1}, 32'h1);
    we_b = 1'b1; wa_b = 5'd9; wd_b = 32'h55;
    #1;
    check("r9_busy_bypass", {31'b0, busy1}, 32'h0);
    check("r9_rd_bypass", rd1, 32'h55);
    tick();
    idle();
    #1;
    check("r9_free", {31'b0, busy1}, 32'h0);
    check("r9_data", rd1, 32'h55);
    check("r9_sb_err", {31'b0, sb_err}, 32'h0);

    // Collision on r3 (issued first so port B is a legal writeback)
    issue_valid = 1'b1; issue_dst = 5'd3;
    tick();
    idle();
    we_a = 1'b1; wa_a = 5'd3; wd_a = 32'h1;
    we_b = 1'b1; wa_b = 5'd3; wd_b = 32'h2;
    ra1 = 5'd3;
    #1;
    check("collide_bypass", rd1, 32'h2);
    tick();
    idle();
    #1;
    check("collide_data", rd1, 32'h2);
    check("collide_pulse", {31'b0, collide}, 32'h1);
    check("collide_sb_err", {31'b0, sb_err}, 32'h0);
    tick();
    check("collide_drop", {31'b0, collide}, 32'h0);

    // Simultaneous issue and writeback on busy r4
    issue_valid = 1'b1; issue_dst = 5'd4;
    tick();
    idle();
    issue_valid = 1'b1; issue_dst = 5'd4;
    we_b = 1'b1; wa_b = 5'd4; wd_b = 32'hBEEF;
    #1;
    check("r4_reissue_ok", {31'b0, issue_ok}, 32'h1);
    tick();
    idle();
    ra2 = 5'd4;
    #1;
    check("r4_busy", {31'b0, busy2}, 32'h1);
    check("r4_data", rd2, 32'hBEEF);
    check("r4_sb_err", {31'b0, sb_err}, 32'h0);

    // Stray writeback to r6
    we_b = 1'b1; wa_b = 5'd6; wd_b = 32'h66;
    tick();
    idle();
    #1;
    check("stray_sb_err", {31'b0, sb_err}, 32'h1);
    tick();
    check("sticky_sb_err", {31'b0, sb_err}, 32'h1);

    // Async reset mid-cycle with r2 busy and holding data
    issue_valid = 1'b1; issue_dst = 5'd2;
    tick();
    idle();
    we_a = 1'b1; wa_a = 5'd2; wd_a = 32'h77;
    tick();
    idle();
    ra2 = 5'd2;
    #1;
    check("r2_busy_pre", {31'b0, busy2}, 32'h1);
    check("r2_data_pre", rd2, 32'h77);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst_busy2", {31'b0, busy2}, 32'h0);
    check("rst_rd2", rd2, 32'h0);
    check("rst_sb_err", {31'b0, sb_err}, 32'h0);
    reset = 1'b0;
    issue_valid = 1'b1; issue_dst = 5'd2;
    #1;
    check("rst_issue2_ok", {31'b0, issue_ok}, 32'h1);
    tick();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
